ie_branch_ctrl: RTL

Multi-cycle sequencer for the execution stage's control-flow operations: BCC, BCS, BEQ, BMI, BNE, BPL, BVC, BVS and JMP (absolute and indirect), using internal opcodes 8'h04-8'h0B and 8'h1C.
- Evaluates branch conditions against the status register.
- Computes the target with 6502 page-cross timing.
- Fetches indirect JMP vectors through a memory read handshake.
- Issues a single PC-write strobe to the fetch unit.

---
 rtl/ie_defs.sv | 30 +++
 rtl/ie_branch_cond.sv | 33 +++
 rtl/ie_branch_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ie_defs.sv
// Shared definitions for the execution-stage control-flow sequencer:
// opcodes, status flag positions and the sequencer state encoding.
package ie_defs;

   localparam logic [7:0] OP_BCC = 8'h04;
   localparam logic [7:0] OP_BCS = 8'h05;
   localparam logic [7:0] OP_BEQ = 8'h06;
   localparam logic [7:0] OP_BMI = 8'h07;
   localparam logic [7:0] OP_BNE = 8'h08;
   localparam logic [7:0] OP_BPL = 8'h09;
   localparam logic [7:0] OP_BVC = 8'h0A;
   localparam logic [7:0] OP_BVS = 8'h0B;
   localparam logic [7:0] OP_JMP = 8'h1C;

   localparam int FLAG_N = 7;
   localparam int FLAG_V = 6;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_EVAL   = 3'd1,
      ST_ADD    = 3'd2,
      ST_FIX    = 3'd3,
      ST_IND_LO = 3'd4,
      ST_IND_HI = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

endpackage

// File: rtl/ie_branch_cond.sv
// Branch condition decoder: flags whether an opcode is a conditional branch
// and whether its condition holds for the given status register.
module ie_branch_cond
   import ie_defs::*;
(
   input  logic [7:0] opcode,
   input  logic [7:0] status,
   output logic       is_branch,
   output logic       cond_true
);

   // Bits 5:2 of P (D, I, B and the spare bit) never steer a branch.
   logic status_unused_s;
   assign status_unused_s = ^status[5:2];

   // Decode the opcode and test the single flag it depends on.
   always_comb begin
      is_branch = 1'b1;
      cond_true = 1'b0;
      case (opcode)
         OP_BCC:  cond_true = ~status[FLAG_C];
         OP_BCS:  cond_true =  status[FLAG_C];
         OP_BEQ:  cond_true =  status[FLAG_Z];
         OP_BNE:  cond_true = ~status[FLAG_Z];
         OP_BMI:  cond_true =  status[FLAG_N];
         OP_BPL:  cond_true = ~status[FLAG_N];
         OP_BVC:  cond_true = ~status[FLAG_V];
         OP_BVS:  cond_true =  status[FLAG_V];
         default: is_branch = 1'b0;
      endcase
   end

endmodule

// File: rtl/ie_branch_ctrl.sv
// Multi-cycle control-flow sequencer: branch evaluation with page-cross
// timing, absolute/indirect JMP, and a single PC-write strobe on completion.
module ie_branch_ctrl
   import ie_defs::*;
#(
   parameter int ADDR_W       = 16,
   parameter bit IND_PAGE_BUG = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        opcode,
   input  logic              jmp_ind,
   input  logic [7:0]        status,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] operand,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic              mem_ack,
   input  logic [7:0]        mem_data,
   output logic              busy,
   output logic              done,
   output logic              taken,
   output logic              pc_we,
   output logic [ADDR_W-1:0] new_pc,
   output logic [1:0]        extra_cyc,
   output logic              err
);

   state_t            state_r;
   state_t            state_nxt_s;
   logic [7:0]        opcode_r;
   logic              jmp_ind_r;
   logic [7:0]        status_r;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] operand_r;
   logic [7:0]        lo_r;

   logic              is_branch_s;
   logic              cond_true_s;
   logic [ADDR_W-1:0] target_s;
   logic              same_page_s;
   logic [ADDR_W-1:0] hi_addr_s;
   logic [ADDR_W-1:0] ind_pc_s;

   logic              fin_taken_s;
   logic              fin_err_s;
   logic [ADDR_W-1:0] fin_pc_s;
   logic [1:0]        fin_extra_s;

   ie_branch_cond u_cond (
      .opcode    (opcode_r),
      .status    (status_r),
      .is_branch (is_branch_s),
      .cond_true (cond_true_s)
   );

   assign target_s    = pc_r + {{(ADDR_W-8){operand_r[7]}}, operand_r[7:0]};
   assign same_page_s = (target_s[ADDR_W-1:8] == pc_r[ADDR_W-1:8]);
   // NMOS parts never carry into the pointer's high byte when fetching the vector MSB.
   assign hi_addr_s   = IND_PAGE_BUG ? {operand_r[ADDR_W-1:8], operand_r[7:0] + 8'd1}
                                     : operand_r + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign ind_pc_s    = ADDR_W'({mem_data, lo_r});

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic plus the result that is captured on entry to DONE.
   always_comb begin
      state_nxt_s = state_r;
      fin_taken_s = 1'b0;
      fin_err_s   = 1'b0;
      fin_pc_s    = pc_r;
      fin_extra_s = 2'd0;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nxt_s = ST_EVAL;
            else       state_nxt_s = ST_IDLE;
         end
         ST_EVAL: begin
            if (is_branch_s) begin
               if (cond_true_s) state_nxt_s = ST_ADD;
               else             state_nxt_s = ST_DONE;
            end else if (opcode_r == OP_JMP) begin
               if (jmp_ind_r) begin
                  state_nxt_s = ST_IND_LO;
               end else begin
                  state_nxt_s = ST_DONE;
                  fin_taken_s = 1'b1;
                  fin_pc_s    = operand_r;
               end
            end else begin
               state_nxt_s = ST_DONE;
               fin_err_s   = 1'b1;
            end
         end
         ST_ADD: begin
            if (same_page_s) begin
               state_nxt_s = ST_DONE;
               fin_taken_s = 1'b1;
               fin_pc_s    = target_s;
               fin_extra_s = 2'd1;
            end else begin
               state_nxt_s = ST_FIX;
            end
         end
         ST_FIX: begin
            state_nxt_s = ST_DONE;
            fin_taken_s = 1'b1;
            fin_pc_s    = target_s;
            fin_extra_s = 2'd2;
         end
         ST_IND_LO: begin
            if (mem_ack) state_nxt_s = ST_IND_HI;
            else         state_nxt_s = ST_IND_LO;
         end
         ST_IND_HI: begin
            if (mem_ack) begin
               state_nxt_s = ST_DONE;
               fin_taken_s = 1'b1;
               fin_pc_s    = ind_pc_s;
            end else begin
               state_nxt_s = ST_IND_HI;
            end
         end
         ST_DONE:  state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   // Request capture and vector low-byte latch.
   always_ff @(posedge clk) begin
      if (!rst) begin
         opcode_r  <= 8'd0;
         jmp_ind_r <= 1'b0;
         status_r  <= 8'd0;
         pc_r      <= {ADDR_W{1'b0}};
         operand_r <= {ADDR_W{1'b0}};
         lo_r      <= 8'd0;
      end else begin
         if (state_r == ST_IDLE && start) begin
            opcode_r  <= opcode;
            jmp_ind_r <= jmp_ind;
            status_r  <= status;
            pc_r      <= pc;
            operand_r <= operand;
         end
         if (state_r == ST_IND_LO && mem_ack) begin
            lo_r <= mem_data;
         end
      end
   end

   // Registered outputs, derived from the state being entered.
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         pc_we     <= 1'b0;
         taken     <= 1'b0;
         err       <= 1'b0;
         new_pc    <= {ADDR_W{1'b0}};
         extra_cyc <= 2'd0;
         mem_rd    <= 1'b0;
         mem_addr  <= {ADDR_W{1'b0}};
      end else begin
         busy   <= (state_nxt_s != ST_IDLE);
         done   <= (state_nxt_s == ST_DONE);
         pc_we  <= (state_nxt_s == ST_DONE) && fin_taken_s;
         mem_rd <= (state_nxt_s == ST_IND_LO) || (state_nxt_s == ST_IND_HI);
         if (state_nxt_s == ST_DONE) begin
            taken     <= fin_taken_s;
            err       <= fin_err_s;
            new_pc    <= fin_pc_s;
            extra_cyc <= fin_extra_s;
         end
         if (state_nxt_s == ST_IND_LO) begin
            mem_addr <= operand_r;
         end else if (state_nxt_s == ST_IND_HI) begin
            mem_addr <= hi_addr_s;
         end
      end
   end

endmodule
